// File: rtl/types.sv
// Constants shared by the rename-stage blocks.
package types;
   localparam int ARCH_REGS = 32;
endpackage

// File: rtl/free_list_prefix_count.sv
// Per-slot exclusive popcount of a valid vector, plus the total count.
module prefix_count #(
   parameter int n = 4
) (
   input  logic [n-1:0]                     vec,
   output logic [n-1:0][$clog2(n+1)-1:0]    pre,
   output logic [$clog2(n+1)-1:0]           total
);
   localparam int CW = $clog2(n+1);

   always_comb begin
      logic [CW-1:0] acc;
      acc = '0;
      for (int i = 0; i < n; i++) begin
         pre[i] = acc;
         acc    = acc + CW'(vec[i]);
      end
      total = acc;
   end
endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular queue of unmapped indices with
// speculative (head) and committed (chead) allocation pointers for recovery.
module free_list
   import types::*;
#(
   parameter int prnum = 96,
   parameter int rwd   = 4,
   parameter int cwd   = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [rwd-1:0]                      alloc_req,
   input  logic                                alloc_en,
   output logic                                alloc_ok,
   output logic [rwd-1:0][$clog2(prnum)-1:0]   alloc_prd,
   input  logic [cwd-1:0]                      commit_vld,
   input  logic [cwd-1:0][$clog2(prnum)-1:0]   free_prd,
   input  logic [$clog2(rwd*8):0]              squash_cnt,
   input  logic                                rollback,
   output logic [$clog2(prnum):0]              free_cnt
);
   localparam int PW = $clog2(prnum);
   localparam int CW = PW + 1;
   localparam int QD = prnum - ARCH_REGS;
   localparam int IW = $clog2(QD);
   localparam int RW = $clog2(rwd+1);
   localparam int KW = $clog2(cwd+1);

   logic [PW-1:0] q_q [QD];
   logic [PW-1:0] q_d [QD];
   logic [IW-1:0] head_q, head_d, chead_q, chead_d, tail_q, tail_d;
   logic [CW-1:0] scnt_q, scnt_d, acnt_q, acnt_d, scnt_c;

   logic [rwd-1:0][RW-1:0] r_pre;
   logic [RW-1:0]          n_req;
   logic [cwd-1:0][KW-1:0] c_pre;
   logic [KW-1:0]          n_c;
   logic                   alloc_fire;

   // QD need not be a power of two, so every pointer step wraps explicitly.
   function automatic logic [IW-1:0] ptr_add(input logic [IW-1:0] p, input logic [IW:0] k);
      logic [IW+1:0] s;
      s = {2'b00, p} + {1'b0, k};
      if (s >= (IW+2)'(QD)) s = s - (IW+2)'(QD);
      return IW'(s);
   endfunction

   function automatic logic [IW-1:0] ptr_sub(input logic [IW-1:0] p, input logic [IW:0] k);
      logic [IW+1:0] s;
      s = {2'b00, p} + (IW+2)'(QD) - {1'b0, k};
      if (s >= (IW+2)'(QD)) s = s - (IW+2)'(QD);
      return IW'(s);
   endfunction

   prefix_count #(.n(rwd)) u_req_pc (
      .vec   (alloc_req),
      .pre   (r_pre),
      .total (n_req)
   );

   prefix_count #(.n(cwd)) u_commit_pc (
      .vec   (commit_vld),
      .pre   (c_pre),
      .total (n_c)
   );

   always_comb begin
      alloc_ok = (scnt_q >= CW'(n_req));
      free_cnt = scnt_q;
      for (int i = 0; i < rwd; i++) begin
         alloc_prd[i] = '0;
         if (alloc_req[i]) alloc_prd[i] = q_q[ptr_add(head_q, (IW+1)'(r_pre[i]))];
      end
   end

   assign alloc_fire = alloc_en & alloc_ok & ~rollback & (squash_cnt == '0);

   // Commit always lands; rollback beats squash, which beats allocation.
   always_comb begin
      q_d = q_q;
      for (int i = 0; i < cwd; i++) begin
         if (commit_vld[i]) q_d[ptr_add(tail_q, (IW+1)'(c_pre[i]))] = free_prd[i];
      end
      tail_d  = ptr_add(tail_q, (IW+1)'(n_c));
      chead_d = ptr_add(chead_q, (IW+1)'(n_c));
      acnt_d  = acnt_q;
      scnt_c  = scnt_q + CW'(n_c);
      head_d  = head_q;
      scnt_d  = scnt_c;
      if (rollback) begin
         head_d = chead_d;
         scnt_d = acnt_q;
      end else if (squash_cnt != '0) begin
         head_d = ptr_sub(head_q, (IW+1)'(squash_cnt));
         scnt_d = scnt_c + CW'(squash_cnt);
      end else if (alloc_fire) begin
         head_d = ptr_add(head_q, (IW+1)'(n_req));
         scnt_d = scnt_c - CW'(n_req);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < QD; k++) q_q[k] <= PW'(ARCH_REGS + k);
         head_q  <= '0;
         chead_q <= '0;
         tail_q  <= '0;
         scnt_q  <= CW'(QD);
         acnt_q  <= CW'(QD);
      end else begin
         q_q     <= q_d;
         head_q  <= head_d;
         chead_q <= chead_d;
         tail_q  <= tail_d;
         scnt_q  <= scnt_d;
         acnt_q  <= acnt_d;
      end
   end

   // In-flight allocations are exactly acnt - scnt.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < cwd; i++) assert (!(commit_vld[i] && free_prd[i] == '0));
         assert (scnt_q <= CW'(QD));
         assert (scnt_c <= CW'(QD));
         assert (CW'(squash_cnt) <= acnt_q - scnt_q);
         assert (!(alloc_en && !alloc_ok));
      end
   end
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table, directed corner sequences
// and a queue-model run that wraps the circular buffer several times.
module tb_free_list;
   typedef logic [3:0][6:0] prd4_t;

   typedef struct {
      bit          rst_first;
      logic [3:0]  req;
      logic        en;
      logic [3:0]  cvld;
      prd4_t       fprd;
      logic [5:0]  sq;
      logic        rb;
      logic        exp_ok;
      prd4_t       exp_prd;
      logic [7:0]  exp_cnt;
   } vec_t;

   typedef struct {
      string       tag;
      logic        ok;
      prd4_t       prd;
      logic [7:0]  cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  alloc_req;
   logic        alloc_en;
   logic        alloc_ok;
   prd4_t       alloc_prd;
   logic [3:0]  commit_vld;
   prd4_t       free_prd;
   logic [5:0]  squash_cnt;
   logic        rollback;
   logic [7:0]  free_cnt;

   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   vec_t        tbl[15];
   int          fl[$];
   int          infl[$];
   int          pool[$];
   bit          busy[96];

   free_list #(.prnum(96), .rwd(4), .cwd(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .alloc_req  (alloc_req),
      .alloc_en   (alloc_en),
      .alloc_ok   (alloc_ok),
      .alloc_prd  (alloc_prd),
      .commit_vld (commit_vld),
      .free_prd   (free_prd),
      .squash_cnt (squash_cnt),
      .rollback   (rollback),
      .free_cnt   (free_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic prd4_t p4(input int a0, input int a1, input int a2, input int a3);
      prd4_t r;
      r[0] = 7'(a0);
      r[1] = 7'(a1);
      r[2] = 7'(a2);
      r[3] = 7'(a3);
      return r;
   endfunction

   function automatic vec_t mk(input bit rf, input logic [3:0] req, input logic en,
                               input logic [3:0] cv, input prd4_t fp, input int sq,
                               input logic rb, input logic ok, input prd4_t ep, input int cnt);
      vec_t v;
      v.rst_first = rf;
      v.req = req;
      v.en = en;
      v.cvld = cv;
      v.fprd = fp;
      v.sq = 6'(sq);
      v.rb = rb;
      v.exp_ok = ok;
      v.exp_prd = ep;
      v.exp_cnt = 8'(cnt);
      return v;
   endfunction

   task automatic cmp(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic en, input logic [3:0] cv,
                                input prd4_t fp, input int sq, input logic rb);
      alloc_req  = req;
      alloc_en   = en;
      commit_vld = cv;
      free_prd   = fp;
      squash_cnt = 6'(sq);
      rollback   = rb;
   endtask

   task automatic expectOutput(input string tag, input logic ok, input prd4_t prd, input int cnt);
      exp_t e;
      e.tag = tag;
      e.ok  = ok;
      e.prd = prd;
      e.cnt = 8'(cnt);
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         cmp("scoreboard_underflow", 1, 0);
         return;
      end
      e = sb.pop_front();
      cmp({e.tag, "_ok"}, int'(alloc_ok), int'(e.ok));
      cmp({e.tag, "_cnt"}, int'(free_cnt), int'(e.cnt));
      for (int k = 0; k < 4; k++)
         cmp($sformatf("%s_prd%0d", e.tag, k), int'(alloc_prd[k]), int'(e.prd[k]));
   endtask

   task automatic doReset();
      @(negedge clk);
      applyStimulus(4'h0, 1'b0, 4'h0, '0, 0, 1'b0);
      rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(4'h0, 1'b0, 4'h0, '0, 0, 1'b0);
      #12 rst = 1'b0;

      @(negedge clk);
      expectOutput("reset_idle", 1'b1, p4(0, 0, 0, 0), 64);
      #1 checkOutput();

      tbl[0]  = mk(1, 4'hF, 1, 4'h0, '0, 0, 0, 1, p4(32, 33, 34, 35), 64);
      tbl[1]  = mk(0, 4'hF, 0, 4'h0, '0, 0, 0, 1, p4(36, 37, 38, 39), 60);
      tbl[2]  = mk(1, 4'hA, 1, 4'h0, '0, 0, 0, 1, p4(0, 32, 0, 33), 64);
      tbl[3]  = mk(0, 4'h0, 0, 4'h0, '0, 0, 0, 1, p4(0, 0, 0, 0), 62);
      tbl[4]  = mk(1, 4'hF, 1, 4'h0, '0, 0, 0, 1, p4(32, 33, 34, 35), 64);
      tbl[5]  = mk(0, 4'hF, 1, 4'h0, '0, 0, 0, 1, p4(36, 37, 38, 39), 60);
      tbl[6]  = mk(0, 4'hF, 1, 4'h0, '0, 3, 0, 1, p4(40, 41, 42, 43), 56);
      tbl[7]  = mk(0, 4'h1, 0, 4'h0, '0, 0, 0, 1, p4(37, 0, 0, 0), 59);
      tbl[8]  = mk(1, 4'hF, 1, 4'h0, '0, 0, 0, 1, p4(32, 33, 34, 35), 64);
      tbl[9]  = mk(0, 4'hF, 1, 4'h0, '0, 0, 0, 1, p4(36, 37, 38, 39), 60);
      tbl[10] = mk(0, 4'h0, 0, 4'h3, p4(1, 2, 0, 0), 0, 1, 1, p4(0, 0, 0, 0), 56);
      tbl[11] = mk(0, 4'h1, 0, 4'h0, '0, 0, 0, 1, p4(34, 0, 0, 0), 64);
      tbl[12] = mk(0, 4'hF, 0, 4'h0, '0, 0, 0, 1, p4(34, 35, 36, 37), 64);
      tbl[13] = mk(0, 4'hF, 1, 4'h0, '0, 0, 1, 1, p4(34, 35, 36, 37), 64);
      tbl[14] = mk(0, 4'hF, 0, 4'h0, '0, 0, 0, 1, p4(34, 35, 36, 37), 64);

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rst_first) doReset();
         @(negedge clk);
         applyStimulus(tbl[i].req, tbl[i].en, tbl[i].cvld, tbl[i].fprd, int'(tbl[i].sq), tbl[i].rb);
         expectOutput($sformatf("vec%0d", i), tbl[i].exp_ok, tbl[i].exp_prd, int'(tbl[i].exp_cnt));
         #1 checkOutput();
      end

      // Drain to two free entries, then a three-wide request must stall
      // while a same-cycle release refills the slot at the wrap point.
      doReset();
      for (int g = 0; g < 15; g++) begin
         @(negedge clk);
         applyStimulus(4'hF, 1'b1, 4'h0, '0, 0, 1'b0);
      end
      @(negedge clk);
      applyStimulus(4'h3, 1'b1, 4'h0, '0, 0, 1'b0);
      @(negedge clk);
      applyStimulus(4'h7, 1'b0, 4'h1, p4(5, 0, 0, 0), 0, 1'b0);
      expectOutput("empty_stall", 1'b0, p4(94, 95, 32, 0), 2);
      #1 checkOutput();
      @(negedge clk);
      applyStimulus(4'h7, 1'b1, 4'h0, '0, 0, 1'b0);
      expectOutput("refill_wrap", 1'b1, p4(94, 95, 5, 0), 3);
      #1 checkOutput();
      @(negedge clk);
      applyStimulus(4'h1, 1'b0, 4'h0, '0, 0, 1'b0);
      expectOutput("empty_single", 1'b0, p4(33, 0, 0, 0), 0);
      #1 checkOutput();

      // Asynchronous reset in the middle of a group, away from any edge.
      doReset();
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         applyStimulus(4'hF, 1'b1, 4'h0, '0, 0, 1'b0);
      end
      @(negedge clk);
      applyStimulus(4'hF, 1'b1, 4'h0, '0, 0, 1'b0);
      #2 rst = 1'b1;
      expectOutput("rst_mid", 1'b1, p4(32, 33, 34, 35), 64);
      #1 checkOutput();
      applyStimulus(4'h0, 1'b0, 4'h0, '0, 0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(4'hF, 1'b0, 4'h0, '0, 0, 1'b0);
      expectOutput("rst_after", 1'b1, p4(32, 33, 34, 35), 64);
      #1 checkOutput();

      // Steady allocate/commit traffic; head and tail each wrap several times.
      doReset();
      fl.delete();
      infl.delete();
      pool.delete();
      for (int k = 32; k < 96; k++) fl.push_back(k);
      for (int k = 1; k < 32; k++) pool.push_back(k);
      for (int k = 0; k < 96; k++) busy[k] = (k < 32);
      for (int cyc = 0; cyc < 60; cyc++) begin
         logic [3:0] cv;
         prd4_t      fp;
         int         nc;
         int         f;
         logic       en;
         @(negedge clk);
         cv = '0;
         fp = '0;
         nc = (infl.size() >= 6) ? 4 : 0;
         en = (fl.size() >= 4);
         expectOutput($sformatf("wrap%0d", cyc), en, p4(fl[0], fl[1], fl[2], fl[3]), fl.size());
         for (int k = 0; k < nc; k++) begin
            pool.push_back(infl.pop_front());
            f = pool.pop_front();
            fp[k] = 7'(f);
            cv[k] = 1'b1;
         end
         applyStimulus(4'hF, en, cv, fp, 0, 1'b0);
         #1 checkOutput();
         if (en) begin
            for (int k = 0; k < 4; k++) begin
               cmp("wrap_nonzero", int'(alloc_prd[k] != 7'd0), 1);
               cmp("wrap_unique", int'(busy[alloc_prd[k]]), 0);
               busy[fl[0]] = 1'b1;
               infl.push_back(fl.pop_front());
            end
         end
         for (int k = 0; k < nc; k++) begin
            fl.push_back(int'(fp[k]));
            busy[fp[k]] = 1'b0;
         end
      end
      @(negedge clk);
      applyStimulus(4'h0, 1'b0, 4'h0, '0, 0, 1'b0);
      cmp("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
